// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS seven-segment driver: prescaled digit scan, anode
// blanking, leading-zero suppression, decimal points and frame-synchronous value loading.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PSC_W = $clog2(SCAN_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [PSC_W-1:0]      PSC_LAST  = PSC_W'(SCAN_DIV - 1);
    localparam logic [PSC_W-1:0]      PSC_BLANK = PSC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] hex;
        logic [NUM_DIGITS-1:0]      dp;
    } disp_t;

    disp_t                 incoming, shadow, active;
    logic [PSC_W-1:0]      psc;
    logic [IDX_W-1:0]      idx;
    logic                  tick, boundary;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic [3:0]            cur_hex;
    logic                  cur_dp, suppress;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_sel;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b000_0001;
            4'h1: return 7'b100_1111;
            4'h2: return 7'b001_0010;
            4'h3: return 7'b000_0110;
            4'h4: return 7'b100_1100;
            4'h5: return 7'b010_0100;
            4'h6: return 7'b010_0000;
            4'h7: return 7'b000_1111;
            4'h8: return 7'b000_0000;
            4'h9: return 7'b000_0100;
            4'hA: return 7'b000_1000;
            4'hB: return 7'b110_0000;
            4'hC: return 7'b011_0001;
            4'hD: return 7'b100_0010;
            4'hE: return 7'b011_0000;
            default: return 7'b011_1000;
        endcase
    endfunction

    assign incoming.hex = value;
    assign incoming.dp  = dp_in;
    assign tick         = enable && (psc == PSC_LAST);
    assign boundary     = tick && (idx == IDX_LAST);
    assign frame_done   = boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            idx <= '0;
        end else if (enable) begin
            if (tick) begin
                psc <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                psc <= psc + 1'b1;
            end
        end
    end

    // Active only moves at the frame boundary so a frame never mixes two values;
    // a LOAD coinciding with the boundary bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load)     shadow <= incoming;
            if (boundary) active <= load ? incoming : shadow;
        end
    end

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (active.hex[i] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end

    assign cur_hex  = active.hex[idx];
    assign cur_dp   = active.dp[idx];
    assign suppress = lz_en && (idx != '0) && lead_zero[idx];
    assign seg_next = suppress ? 7'h7F : hex2seg(cur_hex);
    assign an_sel   = NUM_DIGITS'(1) << idx;

    // Anodes stay off for the first BLANK_CYCLES of a slot while SEG settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= AN_OFF;
        end else if (!enable) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            dp  <= ~cur_dp;
            an  <= (psc >= PSC_BLANK) ? (an_sel ^ AN_OFF) : AN_OFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position reference model checked every cycle,
// plus directed scenarios with literal expected segment/anode patterns.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FP = ND * SD;

    localparam logic [6:0] SEGTAB [16] = '{
        7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
        7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
        7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
        7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000};

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, load = 1'b0, lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0, errors = 0;
    bit run_chk = 0;

    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    logic [3:0] cap_an  [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
        .load(load), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position inside the frame counted in enabled cycles.
    int          pos = 0;
    logic [15:0] sh_v = '0, act_v = '0;
    logic [3:0]  sh_dp = '0, act_dp = '0;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [3:0]  exp_an = 4'hF;

    function automatic logic [6:0] m_seg(input int p, input logic [15:0] a, input logic lz);
        int slot;
        logic [15:0] hi;
        slot = p / SD;
        hi = a >> (4 * slot);
        if (lz && slot != 0 && hi == 16'h0) return 7'h7F;
        return SEGTAB[hi[3:0]];
    endfunction

    function automatic logic [3:0] m_an(input int p);
        logic [3:0] oh;
        oh = 4'b0001 << (p / SD);
        return ((p % SD) >= BC) ? ~oh : 4'hF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 0; sh_v <= '0; act_v <= '0; sh_dp <= '0; act_dp <= '0;
            exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_an <= 4'hF;
        end else begin
            if (enable) begin
                exp_seg <= m_seg(pos, act_v, lz_en);
                exp_dp  <= ~act_dp[pos / SD];
                exp_an  <= m_an(pos);
            end else begin
                exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_an <= 4'hF;
            end
            if (enable && pos == FP - 1) begin
                act_v  <= load ? value : sh_v;
                act_dp <= load ? dp_in : sh_dp;
            end
            if (load) begin
                sh_v  <= value;
                sh_dp <= dp_in;
            end
            if (enable) pos <= (pos + 1) % FP;
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_chk) begin
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("dp", 32'(dp), 32'(exp_dp));
            chk("an", 32'(an), 32'(exp_an));
            chk("frame_done", 32'(frame_done), 32'(enable && pos == FP - 1));
        end
    end

    task automatic wait_fd(output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) got = 1;
        end
        if (!got) chk("fd_timeout", 32'd0, 32'd1);
    endtask

    task automatic capture();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cap_seg[k] = seg;
            cap_dp[k]  = dp;
            cap_an[k]  = an;
        end
    endtask

    task automatic next_frame();
        int n;
        wait_fd(n);
        @(negedge clk);
        capture();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        int n, last, fdc, multi, g;
        int cnt [4];
        logic [3:0] on;

        // reset state and first frame timing
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_chk = 1;
        wait_fd(n);
        chk("first_fd_latency", 32'(n), 32'd16);

        // basic frame content
        do_load(16'h1A3F, 4'b0100);
        next_frame();
        chk("t2_an_blank", 32'(cap_an[0]), 32'hF);
        for (int k = 1; k < 4; k++) chk("t2_an_slot0", 32'(cap_an[k]), 32'hE);
        chk("t2_seg_early", 32'(cap_seg[0]), 32'(7'b011_1000));
        chk("t2_seg_d0", 32'(cap_seg[1]), 32'(7'b011_1000));
        chk("t2_dp_d0", 32'(cap_dp[1]), 32'h1);
        chk("t2_seg_d1", 32'(cap_seg[5]), 32'(7'b000_0110));
        chk("t2_seg_d2", 32'(cap_seg[9]), 32'(7'b000_1000));
        chk("t2_dp_d2", 32'(cap_dp[9]), 32'h0);
        chk("t2_seg_d3", 32'(cap_seg[13]), 32'(7'b100_1111));
        chk("t2_an_d3", 32'(cap_an[13]), 32'(4'b0111));

        // leading-zero suppression
        lz_en = 1'b1;
        do_load(16'h0050, 4'b0000);
        next_frame();
        chk("t3_seg_d3", 32'(cap_seg[13]), 32'h7F);
        chk("t3_an_d3", 32'(cap_an[13]), 32'(4'b0111));
        chk("t3_seg_d2", 32'(cap_seg[9]), 32'h7F);
        chk("t3_an_d2", 32'(cap_an[9]), 32'(4'b1011));
        chk("t3_seg_d1", 32'(cap_seg[5]), 32'(7'b010_0100));
        chk("t3_seg_d0", 32'(cap_seg[1]), 32'(7'b000_0001));
        do_load(16'h0000, 4'b0000);
        next_frame();
        chk("t3z_seg_d3", 32'(cap_seg[13]), 32'h7F);
        chk("t3z_seg_d1", 32'(cap_seg[5]), 32'h7F);
        chk("t3z_seg_d0", 32'(cap_seg[1]), 32'(7'b000_0001));

        // mid-frame load is deferred; boundary load applies immediately
        lz_en = 1'b0;
        wait_fd(n);
        repeat (6) @(posedge clk);
        #1;
        do_load(16'h1234, 4'b0000);
        value = 16'h5678;
        wait_fd(n);
        chk("t4_old_frame", 32'(seg), 32'(7'b000_0001));
        @(negedge clk);
        capture();
        chk("t4_d0", 32'(cap_seg[1]), 32'(7'b100_1100));
        chk("t4_d1", 32'(cap_seg[5]), 32'(7'b000_0110));
        chk("t4_d2", 32'(cap_seg[9]), 32'(7'b001_0010));
        chk("t4_d3", 32'(cap_seg[13]), 32'(7'b100_1111));
        wait_fd(n);
        value = 16'h9999;
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        capture();
        for (int s = 0; s < 4; s++) chk("t4_boundary_9", 32'(cap_seg[4*s+1]), 32'(7'b000_0100));

        // pause mid slot 2
        wait_fd(n);
        repeat (10) @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("t5_an_dark", 32'(an), 32'hF);
                chk("t5_seg_dark", 32'(seg), 32'h7F);
                chk("t5_dp_dark", 32'(dp), 32'h1);
            end
            chk("t5_no_fd", 32'(frame_done), 32'h0);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        wait_fd(n);
        chk("t5_resume_latency", 32'(n), 32'd7);

        // free run
        wait_fd(n);
        last = 0; fdc = 0; multi = 0;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fdc++;
                chk("t6_fd_period", 32'(k - last), 32'd16);
                last = k;
            end
            on = ~an;
            if ($countones(on) > 1) multi++;
            for (int d = 0; d < 4; d++) if (on[d]) cnt[d]++;
        end
        chk("t6_fd_count", 32'(fdc), 32'd5);
        chk("t6_multi_an", 32'(multi), 32'd0);
        for (int d = 0; d < 4; d++) chk("t6_an_duty", 32'(cnt[d]), 32'd15);

        // asynchronous reset while a digit is lit
        g = 0;
        @(negedge clk);
        while (an == 4'hF && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("t1_lit_before", 32'(an != 4'hF), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_seg", 32'(seg), 32'h7F);
        chk("t1_async_dp", 32'(dp), 32'h1);
        chk("t1_async_an", 32'(an), 32'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fd(n);
        chk("t1_fd_after_rst", 32'(n), 32'd16);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
